// File: rtl/cdu_read_counter.sv
// cdu_read_counter: CDU read counter tracking loop with switch decode, lock detect and AGC pulse handshake
module cdu_read_counter #(
    parameter int CW               = 16,
    parameter int COARSE_STEP_LOG2 = 6,
    parameter int SETTLE           = 8,
    parameter int LOCK_CNT         = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          cmp_valid,
    input  logic          err_pos,
    input  logic          err_neg,
    input  logic          coarse_err,
    output logic [13:0]   d_n,
    output logic [CW-1:0] angle,
    output logic          locked,
    output logic          inc_req,
    output logic          inc_dir,
    input  logic          inc_ack
);
    localparam int TW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    localparam int NW = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0] CSTEP = CW'(1) << COARSE_STEP_LOG2;
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE} state_t;
    state_t state, n_state;
    logic [TW-1:0] timer, n_timer;
    logic [NW-1:0] null_cnt, n_null;
    logic [CW-1:0] n_angle, fstep;
    logic [13:0] n_d;
    logic fine, n_fine, n_locked, n_req, n_dir, step;

    function automatic logic [13:0] decode(input logic [CW-1:0] a, input logic f);
        logic [1:0] q, o;
        q = a[CW-1:CW-2];
        o = a[CW-3:CW-4];
        return {f ? 6'b110010 : 6'b001101, ~(q[1] ^ q[0]), q[1] ^ q[0], ~q[1], q[1], ~(4'b0001 << o)};
    endfunction

    always_comb begin
        n_state  = state;
        n_timer  = timer;
        n_angle  = angle;
        n_fine   = fine;
        n_locked = locked;
        n_null   = null_cnt;
        n_req    = inc_req && !inc_ack;
        n_dir    = inc_dir;
        step     = err_pos ^ err_neg;
        fstep    = err_pos ? angle + CW'(1) : angle - CW'(1);
        if (!en) begin
            n_state  = ST_IDLE;
            n_fine   = 1'b0;
            n_locked = 1'b0;
            n_null   = '0;
        end else if (state == ST_IDLE) begin
            n_state = ST_SETTLE;
            n_timer = TW'(SETTLE - 1);
        end else if (state == ST_SETTLE) begin
            n_state = timer == '0 ? ST_SAMPLE : ST_SETTLE;
            n_timer = timer - TW'(1);
        end else if (cmp_valid && !inc_req) begin
            if (!fine) begin
                if (!coarse_err) begin
                    n_fine  = 1'b1;
                    n_null  = '0;
                    n_state = ST_SETTLE;
                    n_timer = TW'(SETTLE - 1);
                end else if (step) begin
                    n_angle = err_pos ? angle + CSTEP : angle - CSTEP;
                    n_state = ST_SETTLE;
                    n_timer = TW'(SETTLE - 1);
                end
            end else if (coarse_err) begin
                n_fine   = 1'b0;
                n_locked = 1'b0;
                n_null   = '0;
                n_state  = ST_SETTLE;
                n_timer  = TW'(SETTLE - 1);
            end else if (step) begin
                n_angle = fstep;
                n_req   = 1'b1;
                n_dir   = err_pos;
                n_null  = '0;
                if (decode(fstep, 1'b1) != decode(angle, 1'b1)) begin
                    n_state = ST_SETTLE;
                    n_timer = TW'(SETTLE - 1);
                end
            end else begin
                n_null   = null_cnt == NW'(LOCK_CNT) ? null_cnt : null_cnt + NW'(1);
                n_locked = locked || n_null == NW'(LOCK_CNT);
            end
        end
        n_d = n_state == ST_IDLE ? 14'h3FFF : decode(n_angle, n_fine);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            timer    <= '0;
            angle    <= '0;
            fine     <= 1'b0;
            locked   <= 1'b0;
            null_cnt <= '0;
            inc_req  <= 1'b0;
            inc_dir  <= 1'b0;
            d_n      <= 14'h3FFF;
        end else begin
            state    <= n_state;
            timer    <= n_timer;
            angle    <= n_angle;
            fine     <= n_fine;
            locked   <= n_locked;
            null_cnt <= n_null;
            inc_req  <= n_req;
            inc_dir  <= n_dir;
            d_n      <= n_d;
        end
    end
endmodule
